// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   GMAX            - widest lookahead group the helpers support
//   grp_pgc_t       - propagate / generate / carry bundle for one group
//   group_carries() - full two-level lookahead carries c[0..GMAX]
//   width_ok()      - legality check for a WIDTH / GROUP pair
package cla_pkg;

  localparam int GMAX = 16;

  typedef struct packed {
    logic [GMAX-1:0] p;
    logic [GMAX-1:0] g;
    logic [GMAX:0]   c;
  } grp_pgc_t;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin, each term a plain
  // AND of P/G bits, so every carry is two logic levels deep in G/P/cin.
  function automatic logic [GMAX:0] group_carries(logic [GMAX-1:0] p,
                                                  logic [GMAX-1:0] g,
                                                  logic            cin);
    logic [GMAX:0] c;
    logic          term;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < GMAX; i++) begin
      term = cin;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  function automatic bit width_ok(int width, int group);
    return (group >= 1) && (group <= GMAX) && (width >= group) &&
           ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
//   a, b : group operand bits (b already conditioned for subtract)
//   cin  : group carry-in
//   s    : group sum bits
//   cout : group carry-out
module cla_group
  import cla_pkg::*;
#(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout
);

  grp_pgc_t pgc;
  logic     unused_carries;

  always_comb begin
    pgc = '0;
    pgc.p[GROUP-1:0] = a ^ b;
    pgc.g[GROUP-1:0] = a & b;
    pgc.c = group_carries(pgc.p, pgc.g, cin);
  end

  assign s    = pgc.p[GROUP-1:0] ^ pgc.c[GROUP-1:0];
  assign cout = pgc.c[GROUP];

  // Carries above the group width are don't-care padding.
  assign unused_carries = ^pgc.c;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit group per stage.
//   Clk, Reset_n        : clock (rising edge), async active-low reset
//   in_valid / in_ready : operand beat handshake
//   A, B, CI, SUB       : operands, carry/borrow-in, subtract select
//   out_valid/out_ready : result beat handshake
//   Sum, CO, OVF        : result, carry-out (no-borrow in SUB), signed overflow
//
// Handshake: a beat moves in when in_valid & in_ready and out when
// out_valid & out_ready. The whole pipe advances together when
// advance = ~out_valid | out_ready; otherwise every register holds.
// Layer 0 captures the conditioned operands; stage k then resolves group k
// into layer k+1, so a beat accepted at edge t appears after edge t+NUM_STAGES.
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OVF
);

  localparam int NUM_STAGES = WIDTH / GROUP;
  localparam int LAYERS     = NUM_STAGES + 1;

  if (!width_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("WIDTH must be a positive multiple of GROUP (GROUP <= %0d)", GMAX);
  end

  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Layer l holds operands (upper groups still pending), resolved sum bits,
  // carry into the next group, valid bit and the overflow of the last group.
  logic [WIDTH-1:0] a_l   [LAYERS];
  logic [WIDTH-1:0] b_l   [LAYERS];
  logic [WIDTH-1:0] s_l   [LAYERS];
  logic             c_l   [LAYERS];
  logic             v_l   [LAYERS];
  logic             ovf_l [LAYERS];

  // Layer 0: subtract is A + ~B + ~CI.
  logic [WIDTH-1:0] a0_r, b0_r;
  logic             c0_r, v0_r;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      a0_r <= '0;
      b0_r <= '0;
      c0_r <= 1'b0;
      v0_r <= 1'b0;
    end else if (advance) begin
      a0_r <= A;
      b0_r <= SUB ? ~B : B;
      c0_r <= SUB ? ~CI : CI;
      v0_r <= in_valid;
    end
  end

  assign a_l[0]   = a0_r;
  assign b_l[0]   = b0_r;
  assign s_l[0]   = '0;
  assign c_l[0]   = c0_r;
  assign v_l[0]   = v0_r;
  assign ovf_l[0] = 1'b0;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [GROUP-1:0] grp_s;
    logic             grp_c;
    logic             c_top;
    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] a_r, b_r, s_r;
    logic             c_r, v_r, ovf_r;

    cla_group #(.GROUP(GROUP)) u_group (
      .a    (a_l[k][k*GROUP +: GROUP]),
      .b    (b_l[k][k*GROUP +: GROUP]),
      .cin  (c_l[k]),
      .s    (grp_s),
      .cout (grp_c)
    );

    always_comb begin
      s_next = s_l[k];
      s_next[k*GROUP +: GROUP] = grp_s;
    end

    // Carry into the group's top bit recovered as p ^ s at that bit.
    assign c_top = a_l[k][k*GROUP+GROUP-1] ^ b_l[k][k*GROUP+GROUP-1] ^
                   grp_s[GROUP-1];

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        a_r   <= '0;
        b_r   <= '0;
        s_r   <= '0;
        c_r   <= 1'b0;
        v_r   <= 1'b0;
        ovf_r <= 1'b0;
      end else if (advance) begin
        a_r   <= a_l[k];
        b_r   <= b_l[k];
        s_r   <= s_next;
        c_r   <= grp_c;
        v_r   <= v_l[k];
        ovf_r <= c_top ^ grp_c;
      end
    end

    assign a_l[k+1]   = a_r;
    assign b_l[k+1]   = b_r;
    assign s_l[k+1]   = s_r;
    assign c_l[k+1]   = c_r;
    assign v_l[k+1]   = v_r;
    assign ovf_l[k+1] = ovf_r;
  end

  assign Sum       = s_l[NUM_STAGES];
  assign CO        = c_l[NUM_STAGES];
  assign OVF       = ovf_l[NUM_STAGES];
  assign out_valid = v_l[NUM_STAGES];

  // Operands are fully consumed by the last stage.
  logic unused_skew;
  assign unused_skew = ^{a_l[NUM_STAGES], b_l[NUM_STAGES]};

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        CI = 1'b0;
  logic        SUB = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Sum;
  logic        CO;
  logic        OVF;

  always #5 Clk = ~Clk;

  pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .CI        (CI),
    .SUB       (SUB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .CO        (CO),
    .OVF       (OVF)
  );

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];   // {CO, OVF, Sum}
  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  int          retired = 0;
  bit          auto_model = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 17-bit addition of the conditioned operands; overflow
  // when both addends share a sign and the result sign differs.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic sub);
    logic [15:0] bn;
    logic [16:0] t;
    logic        ovf;
    bn  = sub ? ~b : b;
    t   = {1'b0, a} + {1'b0, bn} + {16'd0, (sub ? ~ci : ci)};
    ovf = (a[15] == bn[15]) && (t[15] != a[15]);
    return {t[16], ovf, t[15:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sub, input logic ordy);
    in_valid  = v;
    A         = a;
    B         = b;
    CI        = ci;
    SUB       = sub;
    out_ready = ordy;
  endtask

  // Called at a falling edge: settle, record transfers for the coming
  // rising edge, then advance to the next falling edge.
  task automatic tick();
    logic [17:0] e;
    #1;
    if (in_valid && in_ready) begin
      accepted++;
      if (auto_model) exp_q.push_back(model(A, B, CI, SUB));
    end
    if (out_valid && out_ready) begin
      retired++;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL spurious_beat observed=Sum %h expected=no beat", Sum);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("result", {14'd0, CO, OVF, Sum}, {14'd0, e});
      end
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Single directed beat with hand-computed result and exact latency check.
  task automatic one_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sub, input logic [17:0] exp);
    auto_model = 1'b0;
    drive(1'b1, a, b, ci, sub, 1'b1);
    exp_q.push_back(exp);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      #1 chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
      tick();
    end
    #1 chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    tick();
    chk({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [18:0] snap;
    logic [15:0] ta;

    repeat (2) @(negedge Clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, Sum}, 32'd0);
    chk("rst_co_ovf", {30'd0, CO, OVF}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    one_beat("ffff_p_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    one_beat("7fff_p_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    one_beat("8000_m_1",   16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    one_beat("5_m_7",      16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    one_beat("5_m_7_b",    16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFD});
    one_beat("eq_sub",     16'h1234, 16'h1234, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
    one_beat("ci_ripple",  16'h00FF, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0101});
    one_beat("neg_ovf",    16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});

    // Back-to-back stream, full rate.
    auto_model = 1'b1;
    accepted   = 0;
    retired    = 0;
    for (int i = 0; i < 20; i++) begin
      ta = 16'(i * 32'h0F0F);
      drive(1'b1, ta, 16'h1111, 1'b0, 1'b0, 1'b1);
      #1 chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i >= 5) chk("stream_full_rate", {31'd0, out_valid}, 32'd1);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 5; j++) begin
      #1 chk("drain_valid", {31'd0, out_valid}, 32'd1);
      tick();
    end
    #1 chk("drain_idle", {31'd0, out_valid}, 32'd0);
    chk("stream_count", retired, 32'd20);
    chk("stream_queue", exp_q.size(), 32'd0);

    // Backpressure: out_ready low for cycles 6..10.
    accepted = 0;
    retired  = 0;
    for (int c = 0; c < 40 && retired < 8; c++) begin
      if (accepted < 8) begin
        ta = 16'(32'h1357 * (accepted + 1));
        drive(1'b1, ta, 16'hACE1 ^ 16'(accepted), accepted[1], accepted[0],
              !(c >= 6 && c <= 10));
      end else begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, !(c >= 6 && c <= 10));
      end
      #1;
      if (c >= 6 && c <= 10) chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      if (c == 6) begin
        chk("stall_has_output", {31'd0, out_valid}, 32'd1);
        snap = {out_valid, CO, OVF, Sum};
      end
      if (c >= 7 && c <= 10) chk("stall_frozen", {13'd0, out_valid, CO, OVF, Sum}, {13'd0, snap});
      tick();
    end
    chk("stall_accepted", accepted, 32'd8);
    chk("stall_retired", retired, 32'd8);
    chk("stall_queue", exp_q.size(), 32'd0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hA5A5 + 16'(i), 16'h0F0F, 1'b0, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, Sum}, 32'd0);
    chk("midrst_co_ovf", {30'd0, CO, OVF}, 32'd0);
    exp_q.delete();
    @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    one_beat("post_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
